// File: rtl/axi_cross_pkg.sv
// rtl/axi_cross_pkg.sv - shared Gray/binary conversion helpers for the AXI clock-crossing path
package axi_cross_pkg;

  // Callers zero-extend into this width and truncate the result.
  localparam int GRAY_MAXW = 32;
  typedef logic [GRAY_MAXW-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_pub_step.sv
// rtl/gray_pub_step.sv - published write pointer; steps toward the committed pointer one entry per clock
module gray_pub_step
  import axi_cross_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter bit PKT_MODE = 1'b0
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] wbin_n,
  input  logic [ADDRSIZE:0] wcbin,
  output logic [ADDRSIZE:0] wptr
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wpbin;
  logic [PW-1:0] wpbin_n;

  // Single-step publication keeps the Gray output to one bit change per clock.
  always_comb begin
    wpbin_n = wpbin;
    if (!PKT_MODE) begin
      wpbin_n = wbin_n;
    end else if (wpbin != wcbin) begin
      wpbin_n = wpbin + PW'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wpbin <= '0;
      wptr  <= '0;
    end else begin
      wpbin <= wpbin_n;
      wptr  <= PW'(bin2gray(gray_word_t'(wpbin_n)));
    end
  end

endmodule

// File: rtl/wptr_full_pkt.sv
// rtl/wptr_full_pkt.sv - async FIFO write-side pointer, full/almost-full/level/overflow, optional packet commit
module wptr_full_pkt
  import axi_cross_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter bit PKT_MODE = 1'b0
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wcommit,
  input  logic                wabort,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_V = {1'b1, {ADDRSIZE{1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wcbin;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wcbin_n;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_n;
  logic          accept;
  logic          do_abort;
  logic          do_commit;

  assign rbin      = PW'(gray2bin(gray_word_t'(wq2_rptr)));
  assign accept    = winc & ~wfull;
  assign do_abort  = PKT_MODE & wabort;
  assign do_commit = PKT_MODE & wcommit & ~wabort;
  assign waddr     = wbin[ADDRSIZE-1:0];

  // Abort rewinds to the last commit and drops any same-cycle write or commit.
  always_comb begin
    wbin_n  = wbin + PW'(accept);
    wcbin_n = wcbin;
    if (do_abort) begin
      wbin_n = wcbin;
    end
    if (!PKT_MODE) begin
      wcbin_n = wbin_n;
    end else if (do_commit) begin
      wcbin_n = wbin_n;
    end
    lvl_n = wbin_n - rbin;
  end

  // Level is taken against the speculative pointer so uncommitted entries still occupy space.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wcbin     <= '0;
      wlevel    <= '0;
      wfull     <= 1'b0;
      awfull    <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin   <= wbin_n;
      wcbin  <= wcbin_n;
      wlevel <= lvl_n;
      wfull  <= (lvl_n == DEPTH_V);
      awfull <= (lvl_n >= afull_thresh);
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end else if (wclr_ovf) begin
        woverflow <= 1'b0;
      end
    end
  end

  gray_pub_step #(
    .ADDRSIZE (ADDRSIZE),
    .PKT_MODE (PKT_MODE)
  ) u_pub (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wbin_n (wbin_n),
    .wcbin  (wcbin),
    .wptr   (wptr)
  );

endmodule

// File: tb/tb_wptr_full_pkt.sv
// tb/tb_wptr_full_pkt.sv - directed bench for wptr_full_pkt in streaming and packet modes
module tb_wptr_full_pkt;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  logic       winc0 = 0, wcommit0 = 0, wabort0 = 0, wclr0 = 0;
  logic [4:0] thresh0 = 5'd12, rq0 = 5'd0;
  logic [3:0] waddr0;
  logic [4:0] wptr0, wlevel0;
  logic       wfull0, awfull0, wovf0;

  logic       winc1 = 0, wcommit1 = 0, wabort1 = 0, wclr1 = 0;
  logic [4:0] thresh1 = 5'd0, rq1 = 5'd0;
  logic [3:0] waddr1;
  logic [4:0] wptr1, wlevel1;
  logic       wfull1, awfull1, wovf1;

  int checks = 0;
  int errors = 0;

  wptr_full_pkt #(.ADDRSIZE(4), .PKT_MODE(1'b0)) u_dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc0), .wcommit(wcommit0), .wabort(wabort0),
    .wclr_ovf(wclr0), .afull_thresh(thresh0), .wq2_rptr(rq0), .waddr(waddr0),
    .wptr(wptr0), .wfull(wfull0), .awfull(awfull0), .wlevel(wlevel0), .woverflow(wovf0)
  );

  wptr_full_pkt #(.ADDRSIZE(4), .PKT_MODE(1'b1)) u_dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc1), .wcommit(wcommit1), .wabort(wabort1),
    .wclr_ovf(wclr1), .afull_thresh(thresh1), .wq2_rptr(rq1), .waddr(waddr1),
    .wptr(wptr1), .wfull(wfull1), .awfull(awfull1), .wlevel(wlevel1), .woverflow(wovf1)
  );

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [4:0] wb, rb, lvl, prev_wb, prev_p;
    logic       fullm;

    #3;
    chk("rst_wptr0", wptr0, 0);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_wlevel0", wlevel0, 0);
    chk("rst_wfull0", wfull0, 0);
    chk("rst_awfull0", awfull0, 0);
    chk("rst_wovf0", wovf0, 0);
    chk("rst_awfull1_thr0", awfull1, 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    chk("awfull1_first_edge", awfull1, 1);
    chk("wlevel1_first_edge", wlevel1, 0);

    // streaming fill to full, almost-full boundary at 12
    winc0 = 1;
    repeat (11) tick();
    chk("lvl11_wlevel", wlevel0, 11);
    chk("lvl11_awfull", awfull0, 0);
    chk("lvl11_waddr", waddr0, 11);
    chk("lvl11_wptr", wptr0, g(5'd11));
    tick();
    chk("lvl12_wlevel", wlevel0, 12);
    chk("lvl12_awfull", awfull0, 1);
    repeat (3) tick();
    chk("lvl15_wfull", wfull0, 0);
    tick();
    chk("lvl16_wfull", wfull0, 1);
    chk("lvl16_wlevel", wlevel0, 16);
    chk("lvl16_wptr", wptr0, 5'b11000);
    chk("lvl16_waddr", waddr0, 0);
    tick();
    chk("ovf_set", wovf0, 1);
    chk("ovf_waddr", waddr0, 0);
    chk("ovf_wlevel", wlevel0, 16);
    chk("ovf_wptr", wptr0, 5'b11000);
    wclr0 = 1;
    tick();
    chk("ovf_set_beats_clr", wovf0, 1);
    winc0 = 0;
    tick();
    chk("ovf_cleared", wovf0, 0);
    wclr0 = 0;
    rq0 = 5'b00001;
    thresh0 = 5'd16;
    tick();
    chk("rd1_wlevel", wlevel0, 15);
    chk("rd1_wfull", wfull0, 0);
    chk("rd1_awfull", awfull0, 0);

    // wrap-around with a reader keeping up to 16 outstanding
    wb = 5'd16;
    rb = 5'd1;
    fullm = 1'b0;
    prev_p = wptr0;
    for (int i = 0; i < 40; i++) begin
      winc0 = 1;
      if ((i % 3) != 0 && wb != rb) rb = rb + 5'd1;
      rq0 = g(rb);
      prev_wb = wb;
      tick();
      if (!fullm) wb = wb + 5'd1;
      lvl = wb - rb;
      fullm = (lvl == 5'd16);
      chk("wrap_wlevel", wlevel0, lvl);
      chk("wrap_wfull", wfull0, fullm);
      chk("wrap_wptr", wptr0, g(wb));
      chk("wrap_step", $countones(wptr0 ^ prev_p), (wb != prev_wb) ? 1 : 0);
      prev_p = wptr0;
    end
    winc0 = 0;

    // packet mode: hold, then commit and step
    winc1 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pkt_hold_wptr", wptr1, 0);
    end
    chk("pkt_waddr5", waddr1, 5);
    chk("pkt_wlevel5", wlevel1, 5);
    winc1 = 0;
    wcommit1 = 1;
    tick();
    chk("pkt_commit_edge_wptr", wptr1, 0);
    wcommit1 = 0;
    prev_p = wptr1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("pkt_pub_wptr", wptr1, g(5'(k)));
      chk("pkt_pub_step", $countones(wptr1 ^ prev_p), 1);
      prev_p = wptr1;
    end
    tick();
    chk("pkt_pub_done", wptr1, g(5'd5));

    // commit 3, keep writing, abort with a same-cycle write during publication
    winc1 = 1;
    tick();
    tick();
    wcommit1 = 1;
    tick();
    wcommit1 = 0;
    chk("ab_commit_edge_wptr", wptr1, g(5'd5));
    tick();
    chk("ab_pub6", wptr1, g(5'd6));
    tick();
    chk("ab_pub7", wptr1, g(5'd7));
    chk("ab_waddr_pre", waddr1, 10);
    wabort1 = 1;
    tick();
    chk("ab_waddr", waddr1, 8);
    chk("ab_wlevel", wlevel1, 8);
    chk("ab_pub8", wptr1, g(5'd8));
    wabort1 = 0;
    winc1 = 0;
    tick();
    chk("ab_wptr_hold", wptr1, g(5'd8));
    chk("ab_waddr_hold", waddr1, 8);

    // asynchronous reset in the middle of a publication
    winc1 = 1;
    tick();
    tick();
    wcommit1 = 1;
    tick();
    wcommit1 = 0;
    winc1 = 0;
    tick();
    chk("mid_pub9", wptr1, g(5'd9));
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_wptr1", wptr1, 0);
    chk("arst_waddr1", waddr1, 0);
    chk("arst_wlevel1", wlevel1, 0);
    chk("arst_wfull1", wfull1, 0);
    chk("arst_awfull1", awfull1, 0);
    chk("arst_wovf1", wovf1, 0);
    chk("arst_wptr0", wptr0, 0);
    chk("arst_wlevel0", wlevel0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
